// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for start; Sum/Carry hold the last result
  // RUN   | one operand bit processed per edge
  // DONE  | single-cycle done pulse, then back to IDLE
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic             carry_out_q;
  logic             bit_s;
  logic             bit_co;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (bit_s),
    .co (bit_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= c;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= {bit_s, sum_sr[WIDTH-1:1]};
          carry_q <= bit_co;
          cnt     <= cnt + CW'(1);
          // Carry output is a separate flop so it stays put while the next add runs.
          if (cnt == LAST) begin
            carry_out_q <= bit_co;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // carry_q here is the carry into the MSB; XOR with carry out gives signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && cnt == LAST) begin
      ovf <= carry_q ^ bit_co;
    end
  end
`endif

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign Sum   = sum_sr;
  assign Carry = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 8-bit and 2-bit instances against an arithmetic model.
// Overflow checks are included when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       c8 = 1'b0;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       c2 = 1'b0;
  logic       busy2, done2, carry2;
  logic [1:0] sum2;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .c     (c8),
    .busy  (busy8),
    .done  (done8),
    .Sum   (sum8),
    .Carry (carry8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .c     (c2),
    .busy  (busy2),
    .done  (done2),
    .Sum   (sum2),
    .Carry (carry2)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf2)
`endif
  );

  function automatic logic ovf_ref(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] r;
    r = {1'b0, x} + {1'b0, y} + {8'd0, ci};
    return (x[7] == y[7]) && (r[7] != x[7]);
  endfunction

  // Drives one add on the 8-bit instance and returns what it observed.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      output int lat, output logic [7:0] s, output logic cy, output logic ov,
                      output logic pdone, output logic pbusy, output logic [7:0] psum);
    @(negedge clk);
    a8 = ta; b8 = tb_; c8 = tc; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
    s = sum8;
    cy = carry8;
    ov = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ov = ovf8;
`endif
    @(negedge clk);
    pdone = done8;
    pbusy = busy8;
    psum = sum8;
  endtask

  task automatic run2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc,
                      output int lat, output logic [1:0] s, output logic cy);
    @(negedge clk);
    a2 = ta; b2 = tb_; c2 = tc; start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    a2 = ~ta; b2 = ~tb_; c2 = ~tc;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done2) begin
        lat = i;
        break;
      end
    end
    s = sum2;
    cy = carry2;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {busy8, done8, carry8, sum8};
    n_cmp++;
    if (obs !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs8: got %h want 0", obs);
    end
    n_cmp++;
    if ({busy2, done2, carry2, sum2} !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_outputs2: got %h want 0", {busy2, done2, carry2, sum2});
    end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++;
    if (ovf8 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf: got %b want 0", ovf8);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] va [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [7:0] vb [5] = '{8'h3C, 8'h01, 8'hFF, 8'h01, 8'h80};
    logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [7:0] s, psum;
    logic cy, ov, pdone, pbusy;
    logic [8:0] exp;
    for (int k = 0; k < 5; k++) begin
      run8(va[k], vb[k], vc[k], lat, s, cy, ov, pdone, pbusy, psum);
      exp = {1'b0, va[k]} + {1'b0, vb[k]} + {8'd0, vc[k]};
      n_cmp++;
      if (lat !== 9) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got %0d want 9", k, lat);
      end
      n_cmp++;
      if ({cy, s} !== exp) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got %h want %h", k, {cy, s}, exp);
      end
      n_cmp++;
      if (pdone !== 1'b0 || pbusy !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_pulse[%0d]: done=%b busy=%b after done cycle, want 0 0", k, pdone, pbusy);
      end
      n_cmp++;
      if (psum !== exp[7:0]) begin
        n_bad++;
        $display("FAIL directed_hold[%0d]: got %h want %h", k, psum, exp[7:0]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      n_cmp++;
      if (ov !== ovf_ref(va[k], vb[k], vc[k])) begin
        n_bad++;
        $display("FAIL directed_ovf[%0d]: got %b want %b", k, ov, ovf_ref(va[k], vb[k], vc[k]));
      end
`endif
    end
`ifdef SERIAL_ADDER_OVF_EN
    run8(8'h01, 8'h01, 1'b0, lat, s, cy, ov, pdone, pbusy, psum);
    n_cmp++;
    if (ov !== 1'b0 || s !== 8'h02) begin
      n_bad++;
      $display("FAIL ovf_small: got ovf=%b sum=%h want 0 02", ov, s);
    end
`endif
  endtask

  task automatic test_exhaustive_w2();
    int lat;
    logic [1:0] s;
    logic cy;
    logic [2:0] exp;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int z = 0; z < 2; z++) begin
          run2(2'(x), 2'(y), 1'(z), lat, s, cy);
          exp = 3'(x + y + z);
          n_cmp++;
          if (lat !== 3 || {cy, s} !== exp) begin
            n_bad++;
            $display("FAIL w2_add a=%0d b=%0d c=%0d: got lat=%0d res=%0d want lat=3 res=%0d",
                     x, y, z, lat, {cy, s}, exp);
          end
        end
  endtask

  task automatic test_start_held();
    logic [7:0] ca, cb, s;
    logic cc, cy;
    int ndone, extra;
    logic [8:0] exp;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
      a8 = ca; b8 = cb; c8 = cc; start8 = 1'b1;
      @(posedge clk);
      ndone = 0; s = '0; cy = 1'b0;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (done8) begin
          ndone++;
          s = sum8;
          cy = carry8;
          break;
        end
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      // start stays high through the DONE->IDLE edge and must be ignored there
      @(posedge clk);
      #1;
      start8 = 1'b0;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done8 || busy8) extra++;
      end
      exp = {1'b0, ca} + {1'b0, cb} + {8'd0, cc};
      n_cmp++;
      if (ndone !== 1 || extra !== 0) begin
        n_bad++;
        $display("FAIL held_start_count[%0d]: got done=%0d extra=%0d want 1 0", k, ndone, extra);
      end
      n_cmp++;
      if ({cy, s} !== exp) begin
        n_bad++;
        $display("FAIL held_start_result[%0d]: got %h want %h", k, {cy, s}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int dseen, lat;
    logic [7:0] s, psum;
    logic cy, ov, pdone, pbusy;
    logic [11:0] obs;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {1'b0, busy8, done8, carry8, sum8};
`ifdef SERIAL_ADDER_OVF_EN
    obs[11] = ovf8;
`endif
    n_cmp++;
    if (obs !== 12'd0) begin
      n_bad++;
      $display("FAIL midrun_reset_outputs: got %h want 0", obs);
    end
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) dseen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) dseen++;
    end
    n_cmp++;
    if (dseen !== 0) begin
      n_bad++;
      $display("FAIL midrun_no_done: got %0d done/busy cycles want 0", dseen);
    end
    run8(8'h10, 8'h20, 1'b0, lat, s, cy, ov, pdone, pbusy, psum);
    n_cmp++;
    if ({cy, s} !== 9'h030 || lat !== 9) begin
      n_bad++;
      $display("FAIL midrun_recover: got res=%h lat=%0d want 030 9", {cy, s}, lat);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] ra, rb, s, psum;
    logic rc, cy, ov, pdone, pbusy;
    logic [8:0] exp;
    for (int k = 0; k < 25; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run8(ra, rb, rc, lat, s, cy, ov, pdone, pbusy, psum);
      exp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      n_cmp++;
      if (lat !== 9 || {cy, s} !== exp) begin
        n_bad++;
        $display("FAIL random[%0d] %h+%h+%b: got res=%h lat=%0d want %h 9", k, ra, rb, rc, {cy, s}, lat, exp);
      end
`ifdef SERIAL_ADDER_OVF_EN
      n_cmp++;
      if (ov !== ovf_ref(ra, rb, rc)) begin
        n_bad++;
        $display("FAIL random_ovf[%0d]: got %b want %b", k, ov, ovf_ref(ra, rb, rc));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int stamps[$];
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; c8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) stamps.push_back(i);
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (stamps.size() < 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d dones want at least 3", stamps.size());
    end else begin
      n_cmp++;
      if (stamps[1] - stamps[0] !== 10 || stamps[2] - stamps[1] !== 10) begin
        n_bad++;
        $display("FAIL b2b_period: got %0d %0d want 10 10", stamps[1] - stamps[0], stamps[2] - stamps[1]);
      end
      n_cmp++;
      if ({carry8, sum8} !== 9'h033) begin
        n_bad++;
        $display("FAIL b2b_result: got %h want 033", {carry8, sum8});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive_w2();
    test_start_held();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
